// File: rtl/vec_result_collector_pkg.sv
// Shared types and helpers for the vector result collector: FSM encoding,
// lane geometry and the SEW-to-chunk-width mapping.
package vec_result_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WB      = 2'd2
  } state_t;

  localparam int LANE_DATA_W = 64;
  localparam int LANE_IDX_W  = 10;

  function automatic int num_lanes(input int nb_lanes_log2);
    return 1 << nb_lanes_log2;
  endfunction

  function automatic int be_width(input int vlen);
    return vlen / 8;
  endfunction

  // Codes above 3 behave as 64-bit elements.
  function automatic logic [1:0] clamp_sew(input logic [2:0] sew_code);
    return (sew_code > 3'd3) ? 2'd3 : sew_code[1:0];
  endfunction

  // Bits written per lane per beat: the smaller of the element and lane widths.
  function automatic logic [6:0] chunk_width(input logic [1:0] sew, input int lane_width);
    int sew_bits;
    int lane_bits;
    sew_bits  = 8 << sew;
    lane_bits = 1 << lane_width;
    return 7'((sew_bits < lane_bits) ? sew_bits : lane_bits);
  endfunction

endpackage

// File: rtl/vec_lane_merge.sv
// Single-lane masked insert: writes a w-bit chunk at bit idx of the vector,
// marks the covered bytes and flags a write that would run past VLEN.
module vec_lane_merge #(
  parameter int VLEN = 128,
  parameter int CW   = 16
) (
  input  logic [VLEN-1:0]   acc_in,
  input  logic [VLEN/8-1:0] be_in,
  input  logic [CW-1:0]     chunk,
  input  logic [9:0]        idx,
  input  logic [6:0]        w,
  input  logic              valid,
  output logic [VLEN-1:0]   acc_out,
  output logic [VLEN/8-1:0] be_out,
  output logic              oor
);

  logic [10:0]     idx_end;
  logic            in_range;
  logic            do_write;
  logic [VLEN-1:0] low_mask;
  logic [VLEN-1:0] bit_mask;
  logic [VLEN-1:0] bit_data;

  assign idx_end  = {1'b0, idx} + 11'(w);
  assign in_range = (idx_end <= 11'(VLEN));
  assign oor      = valid && !in_range;
  assign do_write = valid && in_range;

  assign low_mask = ~({VLEN{1'b1}} << w);
  assign bit_mask = low_mask << idx;
  assign bit_data = (VLEN'(chunk) & low_mask) << idx;

  // NOTE: outputs get a pass-through default before any condition, so no
  // path through this block leaves them unassigned and no latch is inferred.
  always_comb begin
    acc_out = acc_in;
    be_out  = be_in;
    if (do_write) begin
      acc_out = (acc_in & ~bit_mask) | bit_data;
      for (int b = 0; b < VLEN / 8; b++) begin
        be_out[b] = be_in[b] | (|bit_mask[8*b +: 8]);
      end
    end
  end

endmodule

// File: rtl/vec_result_collector.sv
// Assembles per-lane ALU results into one destination vector on top of the
// old destination contents and hands it to the register file via valid/ready.
module vec_result_collector
  import vec_result_collector_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [4:0]                          vd_addr,
  input  logic [2:0]                          vsew,
  input  logic [VLEN-1:0]                     vd_old,
  input  logic [(LANE_DATA_W<<NB_LANES)-1:0]  lane_vd,
  input  logic [(LANE_IDX_W<<NB_LANES)-1:0]   lane_idx,
  input  logic [(1<<NB_LANES)-1:0]            lane_valid,
  input  logic                                alu_done,
  output logic                                busy,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [4:0]                          wb_addr,
  output logic [VLEN-1:0]                     wb_data,
  output logic [VLEN/8-1:0]                   wb_be,
  output logic                                err
);

  localparam int NL  = num_lanes(NB_LANES);
  localparam int BEW = be_width(VLEN);
  localparam int CW  = 1 << LANE_WIDTH;

  state_t state, next_state;
  logic [1:0] vsew_q;
  logic [6:0] chunk_w;

  logic [VLEN-1:0] acc_chain [NL+1];
  logic [BEW-1:0]  be_chain  [NL+1];
  logic [NL-1:0]   lane_oor;

  assign chunk_w     = chunk_width(vsew_q, LANE_WIDTH);
  assign acc_chain[0] = wb_data;
  assign be_chain[0]  = wb_be;

  // Later lanes see earlier lanes' result, so on overlap the higher lane wins.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    vec_lane_merge #(
      .VLEN (VLEN),
      .CW   (CW)
    ) u_merge (
      .acc_in  (acc_chain[k]),
      .be_in   (be_chain[k]),
      .chunk   (lane_vd[LANE_DATA_W*k +: CW]),
      .idx     (lane_idx[LANE_IDX_W*k +: LANE_IDX_W]),
      .w       (chunk_w),
      .valid   (lane_valid[k] && (state == ST_COLLECT)),
      .acc_out (acc_chain[k+1]),
      .be_out  (be_chain[k+1]),
      .oor     (lane_oor[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start)    next_state = ST_COLLECT;
      ST_COLLECT: if (alu_done) next_state = ST_WB;
      ST_WB:      if (wb_ready) next_state = ST_IDLE;
      default:                  next_state = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign wb_valid = (state == ST_WB);

  // NOTE: the accumulator is a plain register bank rather than a RAM, so it
  // takes the async reset like every other flop and never shows stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsew_q  <= 2'd0;
      wb_addr <= 5'd0;
      wb_data <= '0;
      wb_be   <= '0;
      err     <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, independent of statement order within the block.
      vsew_q  <= clamp_sew(vsew);
      wb_addr <= vd_addr;
      wb_data <= vd_old;
      wb_be   <= '0;
      err     <= 1'b0;
    end else if (state == ST_COLLECT) begin
      wb_data <= acc_chain[NL];
      wb_be   <= be_chain[NL];
      if (|lane_oor) err <= 1'b1;
    end
  end

endmodule

// File: doc/vec_result_collector.md
Name: vec_result_collector

Overview:
Downstream stage of the multi-lane vector ALU wrapper. Consumes the per-lane partial results (lane data, destination bit index, lane-valid, done pulse) and assembles them into one VLEN-bit destination vector, starting from the old destination value so untouched elements are preserved. Presents the assembled vector, a byte-enable mask and the destination register number to the vector register file over a valid/ready writeback handshake.

Parameters:
VLEN, 128, vector register width in bits (multiple of 64, max 512)
LANE_WIDTH, 4, log2 of lane datapath width in bits (4 gives a 16-bit lane slice)
NB_LANES, 2, log2 of lane count (2 gives 4 lanes)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a collection; accepted only in IDLE
vd_addr  in  5  destination vector register number, latched on start
vsew  in  3  element width code (SEW = 8<<vsew), latched on start
vd_old  in  VLEN  current destination contents, latched on start
lane_vd  in  64<<NB_LANES  per-lane result, 64 bits per lane, lane k at [64k+63:64k]
lane_idx  in  10<<NB_LANES  per-lane destination bit index, lane k at [10k+9:10k]
lane_valid  in  1<<NB_LANES  per-lane result valid this cycle
alu_done  in  1  last beat of the operation is present this cycle
busy  out  1  high when not IDLE
wb_valid  out  1  writeback request
wb_ready  in  1  register file accepts writeback
wb_addr  out  5  latched vd_addr
wb_data  out  VLEN  assembled vector
wb_be  out  VLEN/8  byte enables, one per written byte
err  out  1  sticky out-of-range flag, cleared on start

Behaviour:
- Reset (asynchronous, active-high) sets state IDLE, busy=0, wb_valid=0, err=0, wb_addr=0, wb_data=0, wb_be=0. It may assert mid-collection or mid-writeback and aborts it; no partial writeback is issued.
- FSM has three states: IDLE, COLLECT and WB.
- IDLE -> COLLECT on start: latch vd_addr, vsew, vd_old into the accumulator, clear wb_be and err. busy rises the next cycle.
- COLLECT: in every cycle, each lane k with lane_valid[k]=1 writes the chunk lane_vd[k][w-1:0] into accumulator bits [idx+w-1:idx], where idx = lane_idx[k] and w = min(8<<vsew, 1<<LANE_WIDTH).
- Each lane that writes also sets wb_be for the covered bytes. If w < 8, it sets the byte containing idx.
- Lanes write disjoint ranges; if two lanes overlap, the higher lane index wins.
- A lane with idx+w > VLEN is dropped and sets err. Other lanes in the same cycle still write.
- Lane-valid inputs are ignored in IDLE and WB.
- COLLECT -> WB when alu_done=1. The beat present in the same cycle is captured first. wb_valid rises the next cycle, giving one cycle of latency from alu_done.
- alu_done in the same cycle as start is ignored. A collection needs at least one COLLECT cycle.
- WB: wb_data, wb_be and wb_addr are held stable while wb_valid=1 and wb_ready=0.
- WB -> IDLE on wb_valid and wb_ready; wb_valid drops the next cycle.
- start is ignored in WB, including in the handshake cycle, and in COLLECT.
- vsew > 3 on start is treated as vsew=3.

Decomposition:
- Shared package: FSM state encodings (IDLE/COLLECT/WB), a SEW-code-to-chunk-width function, and the VLEN/lane-count derived constants (number of lanes, byte-enable width).
- Natural sub-module: vec_lane_merge, a combinational single-lane masked insert that takes the accumulator, chunk, idx and w and returns the updated vector, byte mask and out-of-range flag. It is instantiated 1<<NB_LANES times in a chain, so the higher lane takes priority.

Test Plan:
1. SEW8, vd_old=0: send 4 beats of 4 lanes. Lane idx = 8·element; lane data = element number 0..15. alu_done on beat 4 -> wb_valid one cycle later, wb_data=0x0F0E0D0C0B0A09080706050403020100, wb_be=0xFFFF.
2. SEW32: 2 beats per element (idx 0,16 then 32,48, ...), chunks 0xBEEF/0xDEAD each pair -> every 32-bit element = 0xDEADBEEF, wb_be=0xFFFF.
3. Partial update: vd_old all 0xAA; only lanes 0-1 valid at idx 0,8 with data 0x11,0x22 -> wb_data low bytes 0x2211, rest 0xAA, wb_be=0x0003.
4. Backpressure: hold wb_ready=0 for 5 cycles and pulse start -> wb_data/wb_be/wb_addr stable, busy=1, start ignored. wb_ready=1 -> back in IDLE next cycle.
5. Out of range: lane 0 idx=120 at SEW16 (w=16) -> err=1, accumulator unchanged. Lane 1 valid write in the same cycle still lands.
6. Reset during COLLECT after 2 beats -> all outputs go to 0 immediately. A new start then collects from the new vd_old only.
